// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst master driving a single-port synchronous memory
// Ports: clk_i/rst_i clock and sync reset; cmd_* burst command (rd_wr 1=write, addr, len=beats-1);
// wdata_* write beat stream in; rdata_valid_o/rdata_o read beat stream out; done_o end-of-burst pulse;
// err_o sticky response timeout; mem_* request/response interface to the memory.
module mem_burst_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_rd_wr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_len_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic                  rdata_valid_o,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  mem_valid_o,
    output logic                  mem_rd_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [WIDTH-1:0]      mem_rdata_i
);
    localparam int BW = ADDR_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DRAIN = 2'd3;

    logic [1:0]            state;
    logic                  dir;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BW-1:0]         beats, issued, resp;
    logic [TW-1:0]         tcnt;
    logic                  resp_hit, outstanding;

    function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign cmd_ready_o   = state == IDLE;
    assign wdata_ready_o = state == WR && issued < beats;
    assign resp_hit      = state != IDLE && mem_ready_i && resp < beats;
    assign outstanding   = issued > resp;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            dir           <= 1'b0;
            addr          <= '0;
            beats         <= '0;
            issued        <= '0;
            resp          <= '0;
            tcnt          <= '0;
            mem_valid_o   <= 1'b0;
            mem_rd_wr_o   <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            rdata_valid_o <= 1'b0;
            rdata_o       <= '0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            mem_valid_o   <= 1'b0;
            rdata_valid_o <= 1'b0;
            done_o        <= 1'b0;
            case (state)
                IDLE: if (cmd_valid_i) begin
                    dir   <= cmd_rd_wr_i;
                    beats <= BW'(cmd_len_i) + BW'(1);
                    resp  <= '0;
                    tcnt  <= '0;
                    err_o <= 1'b0;
                    if (cmd_rd_wr_i) begin
                        issued <= '0;
                        addr   <= cmd_addr_i;
                        state  <= WR;
                    end else begin
                        // the accept edge already presents the first read beat
                        mem_valid_o <= 1'b1;
                        mem_rd_wr_o <= 1'b0;
                        mem_addr_o  <= cmd_addr_i;
                        addr        <= inc(cmd_addr_i);
                        issued      <= BW'(1);
                        state       <= (cmd_len_i == '0) ? DRAIN : RD;
                    end
                end
                RD: begin
                    mem_valid_o <= 1'b1;
                    mem_rd_wr_o <= 1'b0;
                    mem_addr_o  <= addr;
                    addr        <= inc(addr);
                    issued      <= issued + BW'(1);
                    if (issued + BW'(1) == beats) state <= DRAIN;
                end
                WR: if (wdata_valid_i && wdata_ready_o) begin
                    mem_valid_o <= 1'b1;
                    mem_rd_wr_o <= 1'b1;
                    mem_wdata_o <= wdata_i;
                    mem_addr_o  <= addr;
                    addr        <= inc(addr);
                    issued      <= issued + BW'(1);
                    if (issued + BW'(1) == beats) state <= DRAIN;
                end
                default: ;
            endcase
            if (resp_hit) begin
                resp <= resp + BW'(1);
                if (!dir) begin
                    rdata_valid_o <= 1'b1;
                    rdata_o       <= mem_rdata_i;
                end
                if (resp + BW'(1) == beats) begin
                    done_o <= 1'b1;
                    state  <= IDLE;
                end
            end
            // silence watchdog; overrides everything above so the burst is abandoned cleanly
            if (state != IDLE) begin
                if (mem_ready_i) tcnt <= '0;
                else if (outstanding) begin
                    if (tcnt == TW'(TIMEOUT - 1)) begin
                        err_o       <= 1'b1;
                        done_o      <= 1'b1;
                        mem_valid_o <= 1'b0;
                        state       <= IDLE;
                        tcnt        <= '0;
                    end else tcnt <= tcnt + TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: directed + randomized bench for mem_burst_ctrl against a memory model and reference array
module tb_mem_burst_ctrl;
    logic       clk = 0, rst = 1;
    logic       cmd_valid = 0, cmd_ready, cmd_rd_wr = 0;
    logic [3:0] cmd_addr = 0, cmd_len = 0;
    logic       wdata_valid = 0, wdata_ready;
    logic [7:0] wdata = 0;
    logic       rdata_valid, done, err;
    logic [7:0] rdata;
    logic       mem_valid, mem_rd_wr, mem_ready = 0;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata = 0;
    logic       mem_dead = 0;
    logic [7:0] ram [16];
    logic [7:0] ref_mem [16];
    logic [7:0] bdata [16];
    int         cyc = 0, acc = 0;
    int         vectors = 0, miscompares = 0;
    logic [3:0] q_addr [$];
    logic       q_rw [$];
    logic [7:0] q_wd [$];
    int         q_vcyc [$];
    logic [7:0] q_rd [$];
    int         q_rcyc [$];
    int         q_done [$];

    mem_burst_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_rd_wr_i(cmd_rd_wr),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
        .rdata_valid_o(rdata_valid), .rdata_o(rdata), .done_o(done), .err_o(err),
        .mem_valid_o(mem_valid), .mem_rd_wr_o(mem_rd_wr), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory: registered response, ready the cycle after each sampled request
    always @(posedge clk) begin
        mem_ready <= mem_valid && !mem_dead;
        if (mem_valid && !mem_dead) begin
            if (mem_rd_wr) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (mem_valid) begin
            q_addr.push_back(mem_addr);
            q_rw.push_back(mem_rd_wr);
            q_wd.push_back(mem_wdata);
            q_vcyc.push_back(cyc);
        end
        if (rdata_valid) begin
            q_rd.push_back(rdata);
            q_rcyc.push_back(cyc);
        end
        if (done) q_done.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        q_addr.delete(); q_rw.delete(); q_wd.delete(); q_vcyc.delete();
        q_rd.delete(); q_rcyc.delete(); q_done.delete();
    endtask

    task automatic send_cmd(input logic rw, input logic [3:0] a, input logic [3:0] len);
        int g = 0;
        while (!cmd_ready && g < 50) begin
            step(1);
            g++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1; cmd_rd_wr = rw; cmd_addr = a; cmd_len = len;
        step(1);
        acc = cyc;
        cmd_valid = 0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (q_done.size() == 0 && g < 100) begin
            step(1);
            g++;
        end
    endtask

    task automatic do_burst(input logic rw, input logic [3:0] a, input logic [3:0] len,
                            input int gap_at, input int gap_n, input bit rnd, input bit mid_cmd);
        int  n, i, g, gaps;
        bit  hs;
        n = int'(len) + 1;
        clear_q();
        send_cmd(rw, a, len);
        if (rw) begin
            i = 0; g = 0; gaps = gap_n;
            while (i < n && g < 400) begin
                if (i == gap_at && gaps > 0) begin
                    wdata_valid = 0;
                    gaps--;
                end else wdata_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                wdata = wdata_valid ? bdata[i] : 8'($urandom);
                hs = wdata_valid && wdata_ready;
                step(1);
                if (hs) i++;
                g++;
            end
            wdata_valid = 0;
        end else if (mid_cmd) begin
            cmd_valid = 1; cmd_rd_wr = 1; cmd_addr = 0; cmd_len = 15;
            step(2);
            cmd_valid = 0;
        end
        wait_done();
        step(3);
        check("done_count", 32'(q_done.size()), 32'd1);
        check("beats", 32'(q_addr.size()), 32'(n));
        for (int j = 0; j < n && j < q_addr.size(); j++) begin
            logic [3:0] ea;
            ea = 4'((int'(a) + j) % 16);
            check("addr", 32'(q_addr[j]), 32'(ea));
            check("dir", 32'(q_rw[j]), 32'(rw));
            if (rw) begin
                check("wdata", 32'(q_wd[j]), 32'(bdata[j]));
                ref_mem[ea] = bdata[j];
            end else check("vcyc", 32'(q_vcyc[j]), 32'(acc + j));
        end
        if (q_vcyc.size() == n && q_done.size() > 0)
            check("done_cyc", 32'(q_done[0]), 32'(q_vcyc[n-1] + 2));
        if (rw) begin
            for (int j = 0; j < n; j++)
                check("mem_hold", 32'(ram[4'((int'(a) + j) % 16)]), 32'(ref_mem[4'((int'(a) + j) % 16)]));
        end else begin
            check("rbeats", 32'(q_rd.size()), 32'(n));
            for (int j = 0; j < n && j < q_rd.size(); j++) begin
                check("rdata", 32'(q_rd[j]), 32'(ref_mem[4'((int'(a) + j) % 16)]));
                check("rcyc", 32'(q_rcyc[j]), 32'(acc + 2 + j));
            end
        end
        check("idle_after", 32'(cmd_ready), 32'd1);
        check("err_after", 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed hang expected finish");
        $fatal(1);
    end

    initial begin
        step(3);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_rd_wr", 32'(mem_rd_wr), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 0;
        step(2);
        check("idle_mem_valid", 32'(mem_valid), 32'd0);

        // fill the whole memory so every later read has a known reference
        for (int j = 0; j < 16; j++) bdata[j] = 8'($urandom);
        do_burst(1, 0, 15, -1, 0, 0, 0);

        bdata[0] = 8'hA1; bdata[1] = 8'hA2; bdata[2] = 8'hA3; bdata[3] = 8'hA4;
        do_burst(1, 3, 3, -1, 0, 0, 0);
        check("wr_consecutive", 32'(q_vcyc.size() == 4 ? q_vcyc[3] - q_vcyc[0] : -1), 32'd3);
        do_burst(0, 3, 3, -1, 0, 0, 1);
        check("rd_A1", 32'(q_rd.size() > 0 ? q_rd[0] : 8'h00), 32'hA1);

        bdata[0] = 8'h10; bdata[1] = 8'h11; bdata[2] = 8'h12; bdata[3] = 8'h13;
        do_burst(1, 14, 3, 2, 2, 0, 0);
        check("gap_len", 32'(q_vcyc.size() == 4 ? q_vcyc[2] - q_vcyc[1] : -1), 32'd3);
        check("wrap_addr2", 32'(q_addr.size() == 4 ? q_addr[2] : 4'hF), 32'd0);
        do_burst(0, 14, 3, -1, 0, 0, 0);

        clear_q();
        mem_dead = 1;
        send_cmd(0, 5, 0);
        wait_done();
        check("to_done_cyc", 32'(q_done.size() > 0 ? q_done[0] : -1), 32'(acc + 8));
        check("to_err", 32'(err), 32'd1);
        check("to_idle", 32'(cmd_ready), 32'd1);
        check("to_mem_valid", 32'(mem_valid), 32'd0);
        mem_dead = 0;
        step(2);
        check("to_err_sticky", 32'(err), 32'd1);
        do_burst(0, 7, 0, -1, 0, 0, 0);

        clear_q();
        send_cmd(0, 9, 7);
        step(1);
        check("rs_beat2", 32'(mem_valid), 32'd1);
        rst = 1;
        step(1);
        rst = 0;
        check("rs_mem_valid", 32'(mem_valid), 32'd0);
        check("rs_idle", 32'(cmd_ready), 32'd1);
        check("rs_done", 32'(done), 32'd0);
        step(5);
        check("rs_no_done", 32'(q_done.size()), 32'd0);
        check("rs_no_rdata", 32'(q_rd.size()), 32'd0);
        check("rs_beats", 32'(q_vcyc.size()), 32'd2);
        do_burst(0, 2, 0, -1, 0, 0, 0);

        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 16; j++) bdata[j] = 8'($urandom);
            do_burst(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     -1, 0, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
